// File: rtl/sram_pkg.sv
// Shared definitions for the 1RW/1R SRAM: default geometry, init-state encoding
// and the byte-lane merge used by both the write path and the collision bypass.
package sram_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_ADDR_WIDTH = 8;

  typedef enum logic [1:0] {
    INIT_RESET = 2'd0,
    INIT_CLEAR = 2'd1,
    INIT_READY = 2'd2
  } init_state_e;

  // Select the new byte when its lane is enabled, otherwise keep the stored byte.
  function automatic logic [7:0] byte_merge(input logic [7:0] new_b,
                                            input logic [7:0] old_b,
                                            input logic       mask);
    byte_merge = mask ? new_b : old_b;
  endfunction

endpackage

// File: rtl/sram_init_fsm.sv
// Post-reset initialisation sequencer: walks clr_addr over the whole array once,
// raising clr_we each cycle, and holds init_busy until the walk is done.
module sram_init_fsm
  import sram_pkg::*;
#(
  parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  init_busy,
  output logic                  clr_we,
  output logic [ADDR_WIDTH-1:0] clr_addr
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);

  init_state_e           r_state;
  init_state_e           w_next_state;
  logic [ADDR_WIDTH-1:0] r_clr_addr;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= INIT_RESET;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; the first clear write happens on the RESET->CLEAR edge.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      INIT_RESET: begin
        if (CLEAR_ON_RESET != 0) w_next_state = INIT_CLEAR;
        else                     w_next_state = INIT_READY;
      end
      INIT_CLEAR: begin
        if (r_clr_addr == LAST_ADDR) w_next_state = INIT_READY;
        else                         w_next_state = INIT_CLEAR;
      end
      INIT_READY: w_next_state = INIT_READY;
      default:    w_next_state = INIT_RESET;
    endcase
  end

  // Output decode; clearing is suppressed while rst is held so an abort writes nothing.
  always_comb begin
    init_busy = 1'b1;
    clr_we    = 1'b0;
    case (r_state)
      INIT_RESET: begin
        init_busy = 1'b1;
        clr_we    = (!rst) && (CLEAR_ON_RESET != 0);
      end
      INIT_CLEAR: begin
        init_busy = 1'b1;
        clr_we    = !rst;
      end
      INIT_READY: begin
        init_busy = 1'b0;
        clr_we    = 1'b0;
      end
      default: begin
        init_busy = 1'b1;
        clr_we    = 1'b0;
      end
    endcase
  end

  // Clear address counter; parks on the last address rather than wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_clr_addr <= '0;
    end else if (clr_we && (r_clr_addr != LAST_ADDR)) begin
      r_clr_addr <= r_clr_addr + ADDR_ONE;
    end else begin
      r_clr_addr <= r_clr_addr;
    end
  end

  assign clr_addr = r_clr_addr;

endmodule

// File: rtl/sram_1rw1r_param.sv
// Parameterised SRAM with one read/write port (byte-masked) and one read-only port,
// registered outputs, write-first collision bypass and optional zero-fill after reset.
module sram_1rw1r_param
  import sram_pkg::*;
#(
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int NUM_WMASKS     = DATA_WIDTH / 8,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  csb0,
  input  logic                  web0,
  input  logic [NUM_WMASKS-1:0] wmask0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] din0,
  output logic [DATA_WIDTH-1:0] dout0,
  input  logic                  csb1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  output logic [DATA_WIDTH-1:0] dout1,
  output logic                  init_busy
);

  localparam int RAM_DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [RAM_DEPTH];
  logic [DATA_WIDTH-1:0] r_dout0;
  logic [DATA_WIDTH-1:0] r_dout1;

  logic                  w_init_busy;
  logic                  w_clr_we;
  logic [ADDR_WIDTH-1:0] w_clr_addr;
  logic                  w_p0_we;
  logic                  w_p0_re;
  logic                  w_p1_re;
  logic [DATA_WIDTH-1:0] w_merged;
  logic                  w_we;
  logic [ADDR_WIDTH-1:0] w_waddr;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [DATA_WIDTH-1:0] w_p1_data;

  sram_init_fsm #(
    .ADDR_WIDTH     (ADDR_WIDTH),
    .CLEAR_ON_RESET (CLEAR_ON_RESET)
  ) u_init_fsm (
    .clk       (clk),
    .rst       (rst),
    .init_busy (w_init_busy),
    .clr_we    (w_clr_we),
    .clr_addr  (w_clr_addr)
  );

  assign w_p0_we = !w_init_busy && !csb0 && !web0;
  assign w_p0_re = !w_init_busy && !csb0 &&  web0;
  assign w_p1_re = !w_init_busy && !csb1;

  // Byte-lane merge of port 0 write data over the currently stored word.
  always_comb begin
    w_merged = r_mem[addr0];
    for (int i = 0; i < NUM_WMASKS; i++) begin
      w_merged[8*i +: 8] = byte_merge(din0[8*i +: 8], r_mem[addr0][8*i +: 8], wmask0[i]);
    end
  end

  // Single write path: the clear sequence takes priority over port 0.
  always_comb begin
    w_we = w_clr_we || w_p0_we;
    if (w_clr_we) begin
      w_waddr = w_clr_addr;
      w_wdata = '0;
    end else begin
      w_waddr = addr0;
      w_wdata = w_merged;
    end
  end

  // Port 1 sees the merged write data when it collides with a port 0 write.
  always_comb begin
    if (w_p0_we && (addr1 == addr0)) begin
      w_p1_data = w_merged;
    end else begin
      w_p1_data = r_mem[addr1];
    end
  end

  // Storage array; intentionally not reset.
  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[w_waddr] <= w_wdata;
    end
  end

  // Registered read data for both ports; holds when not reading.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dout0 <= '0;
      r_dout1 <= '0;
    end else begin
      if (w_p0_re) r_dout0 <= r_mem[addr0];
      else         r_dout0 <= r_dout0;
      if (w_p1_re) r_dout1 <= w_p1_data;
      else         r_dout1 <= r_dout1;
    end
  end

  assign dout0     = r_dout0;
  assign dout1     = r_dout1;
  assign init_busy = w_init_busy;

endmodule

// File: tb/tb_sram_1rw1r_param.sv
// Self-checking bench for sram_1rw1r_param (default parameters): directed steps plus
// randomized traffic compared every cycle against an array-based reference model.
module tb_sram_1rw1r_param;

  logic        clk;
  logic        rst;
  logic        csb0;
  logic        web0;
  logic [3:0]  wmask0;
  logic [7:0]  addr0;
  logic [31:0] din0;
  logic [31:0] dout0;
  logic        csb1;
  logic [7:0]  addr1;
  logic [31:0] dout1;
  logic        init_busy;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state.
  logic [31:0] m_mem [256];
  logic [31:0] m_d0;
  logic [31:0] m_d1;
  logic        m_busy;
  int          m_left;

  sram_1rw1r_param dut (
    .clk       (clk),
    .rst       (rst),
    .csb0      (csb0),
    .web0      (web0),
    .wmask0    (wmask0),
    .addr0     (addr0),
    .din0      (din0),
    .dout0     (dout0),
    .csb1      (csb1),
    .addr1     (addr1),
    .dout1     (dout1),
    .init_busy (init_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Behaviour at one rising edge: reset, a fixed-length clear, or normal port traffic.
  // Port 1 reads after port 0's write is applied, which gives write-first collisions.
  task automatic model_edge();
    if (rst) begin
      m_d0   = 32'd0;
      m_d1   = 32'd0;
      m_left = 256;
      m_busy = 1'b1;
    end else if (m_busy) begin
      if (m_left > 0) begin
        m_mem[256 - m_left] = 32'd0;
        m_left--;
      end
      m_busy = (m_left > 0);
    end else begin
      if (!csb0 && !web0) begin
        for (int i = 0; i < 4; i++) begin
          if (wmask0[i]) m_mem[addr0][8*i +: 8] = din0[8*i +: 8];
        end
      end
      if (!csb0 && web0) m_d0 = m_mem[addr0];
      if (!csb1)         m_d1 = m_mem[addr1];
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("dout0", dout0, m_d0);
    chk("dout1", dout1, m_d1);
    chk("init_busy", {31'd0, init_busy}, {31'd0, m_busy});
  endtask

  task automatic idle();
    csb0 = 1'b1; web0 = 1'b1; csb1 = 1'b1;
  endtask

  task automatic wr0(input logic [7:0] a, input logic [31:0] d, input logic [3:0] m);
    csb0 = 1'b0; web0 = 1'b0; addr0 = a; din0 = d; wmask0 = m; csb1 = 1'b1;
    tick();
    idle();
  endtask

  task automatic rd(input logic [7:0] a0, input logic [7:0] a1);
    csb0 = 1'b0; web0 = 1'b1; addr0 = a0; csb1 = 1'b0; addr1 = a1;
    tick();
    idle();
  endtask

  // Random port traffic, including write attempts, for n cycles.
  task automatic rand_traffic(input int n);
    for (int k = 0; k < n; k++) begin
      csb0   = ($urandom_range(0, 3) == 0);
      web0   = 1'($urandom_range(0, 1));
      wmask0 = 4'($urandom);
      addr0  = 8'($urandom_range(0, 15));
      din0   = $urandom;
      csb1   = ($urandom_range(0, 3) == 0);
      addr1  = ($urandom_range(0, 1) == 0) ? addr0 : 8'($urandom_range(0, 15));
      tick();
    end
    idle();
  endtask

  // Runs until init_busy falls (bounded) while writes are attempted; returns cycles taken.
  task automatic wait_clear(output int n);
    n = 0;
    while (init_busy !== 1'b0 && n < 1000) begin
      csb0 = 1'b0; web0 = 1'b0; wmask0 = 4'hF; addr0 = 8'h10; din0 = $urandom;
      csb1 = 1'b0; addr1 = 8'h10;
      tick();
      n++;
    end
    idle();
  endtask

  int n_clr;

  initial begin
    rst = 1'b1; csb0 = 1'b1; web0 = 1'b1; wmask0 = 4'h0; addr0 = 8'h00;
    din0 = 32'd0; csb1 = 1'b1; addr1 = 8'h00;
    m_d0 = 32'd0; m_d1 = 32'd0; m_busy = 1'b1; m_left = 256;
    for (int i = 0; i < 256; i++) m_mem[i] = 32'd0;

    // Reset held three cycles with port activity that must be ignored.
    for (int k = 0; k < 3; k++) begin
      csb0 = 1'b0; web0 = 1'b0; wmask0 = 4'hF; din0 = $urandom; csb1 = 1'b0;
      tick();
    end
    chk("rst_dout0", dout0, 32'd0);
    chk("rst_dout1", dout1, 32'd0);
    chk("rst_busy", {31'd0, init_busy}, 32'd1);
    idle();

    rst = 1'b0;
    wait_clear(n_clr);
    chk("clear_len", n_clr, 32'd256);

    rd(8'h00, 8'hFF);
    chk("clr_rd0_00", dout0, 32'd0);
    chk("clr_rd1_ff", dout1, 32'd0);
    rd(8'hFF, 8'h00);
    chk("clr_rd0_ff", dout0, 32'd0);
    chk("clr_rd1_00", dout1, 32'd0);

    // Full-word write then port 0 read.
    wr0(8'h10, 32'hDEADBEEF, 4'hF);
    rd(8'h10, 8'h00);
    chk("wr_full_rd0", dout0, 32'hDEADBEEF);

    // Partial byte write, read back on port 1; dout0 must not change on a write.
    wr0(8'h10, 32'h11223344, 4'h5);
    chk("wr_holds_dout0", dout0, 32'hDEADBEEF);
    rd(8'h00, 8'h10);
    chk("wr_mask_rd1", dout1, 32'hDE22BE44);

    // Same-address collision: port 1 sees write-first merged data.
    wr0(8'h20, 32'hAAAAAAAA, 4'hF);
    csb0 = 1'b0; web0 = 1'b0; addr0 = 8'h20; din0 = 32'hCAFEF00D; wmask0 = 4'h3;
    csb1 = 1'b0; addr1 = 8'h20;
    tick();
    chk("collide_rd1", dout1, 32'hAAAAF00D);
    // Different-address read during a write returns untouched contents.
    csb0 = 1'b0; web0 = 1'b0; addr0 = 8'h20; din0 = 32'h01234567; wmask0 = 4'hF;
    csb1 = 1'b0; addr1 = 8'h10;
    tick();
    chk("nocollide_rd1", dout1, 32'hDE22BE44);
    idle();

    // Deselected ports hold their outputs.
    wr0(8'h30, 32'h12345678, 4'hF);
    rd(8'h30, 8'h30);
    for (int k = 0; k < 5; k++) begin
      addr0 = 8'h20; addr1 = 8'h10;
      tick();
    end
    chk("hold_dout0", dout0, 32'h12345678);
    chk("hold_dout1", dout1, 32'h12345678);

    rand_traffic(1500);

    // Abort the clear at clr_addr 0x80 and verify a full restart.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 128; k++) begin
      csb0 = 1'b0; web0 = 1'b0; wmask0 = 4'hF; addr0 = 8'($urandom); din0 = $urandom;
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wait_clear(n_clr);
    chk("reclear_len", n_clr, 32'd256);
    rd(8'h10, 8'hFF);
    chk("reclear_rd0", dout0, 32'd0);
    chk("reclear_rd1", dout1, 32'd0);

    rand_traffic(500);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sram_1rw1r_param.md
SRAM_1RW1R_PARAM -- requirements
Module: sram_1rw1r_param

Interface
REQ-001 Parameter DATA_WIDTH, default 32: data word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter ADDR_WIDTH, default 8: address width; RAM_DEPTH SHALL equal 2**ADDR_WIDTH.
REQ-003 Parameter NUM_WMASKS, default DATA_WIDTH/8: one write-mask bit per byte lane.
REQ-004 Parameter CLEAR_ON_RESET, default 1: 1 means zero-fill the whole array after reset; 0 means skip the fill.
REQ-005 Port clk, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-006 Port rst, input, 1: reset, synchronous and active-high.
REQ-007 Port csb0, input, 1: port 0 chip select, active low.
REQ-008 Port web0, input, 1: port 0 write enable, active low.
REQ-009 Port wmask0, input, NUM_WMASKS: port 0 byte write mask; bit i enables byte lane i.
REQ-010 Port addr0, input, ADDR_WIDTH: port 0 address.
REQ-011 Port din0, input, DATA_WIDTH: port 0 write data.
REQ-012 Port dout0, output, DATA_WIDTH: port 0 registered read data.
REQ-013 Port csb1, input, 1: port 1 (read-only) chip select, active low.
REQ-014 Port addr1, input, ADDR_WIDTH: port 1 address.
REQ-015 Port dout1, output, DATA_WIDTH: port 1 registered read data.
REQ-016 Port init_busy, output, 1: high while reset or the clear sequence is in progress.

Function
REQ-017 Port 0 write: on a clock edge with csb0=0, web0=0 and init_busy=0, each byte lane i with wmask0[i]=1 SHALL be written at addr0; unmasked lanes SHALL keep their value.
REQ-018 Port 0 read: on a clock edge with csb0=0 and web0=1, dout0 SHALL show mem[addr0] after exactly 1 cycle.
REQ-019 Port 1 read: on a clock edge with csb1=0, dout1 SHALL show mem[addr1] after exactly 1 cycle.
REQ-020 Port 0 write does not change dout0 (dout0 holds).
REQ-021 When a port is deselected or init_busy=1, its dout SHALL hold its previous value; dout never goes X.
REQ-022 Collision: port 0 write and port 1 read in the same cycle at the same address -> dout1 SHALL be write-first data: din0 lanes where wmask0=1, old memory lanes elsewhere.
REQ-023 Port 1 read at a different address from a simultaneous port 0 write SHALL return old contents, unaffected by the write.
REQ-024 Init state machine states: RESET, CLEAR, READY.
- rst=1 -> RESET.
- RESET with rst=0 -> CLEAR if CLEAR_ON_RESET=1, else READY.
- CLEAR writes zero to the address held in counter clr_addr, then increments it.
- CLEAR -> READY after the write to address RAM_DEPTH-1; the counter SHALL NOT wrap into a second pass.
REQ-025 init_busy SHALL be 1 in RESET and CLEAR and 0 in READY; a clear takes exactly RAM_DEPTH cycles after rst falls.
REQ-026 Port inputs are ignored while init_busy=1.
REQ-027 rst asserted during CLEAR SHALL abort the clear; it restarts from address 0 after rst falls.
REQ-028 With CLEAR_ON_RESET=0, memory contents are undefined after reset and SHALL NOT be modified by reset.

Reset
REQ-029 While rst=1: dout0=0, dout1=0, init_busy=1, clr_addr=0, state=RESET.
REQ-030 Reset SHALL NOT clear the array directly; only the CLEAR sequence zeroes it.

Structure
REQ-031 A shared package sram_pkg SHALL hold the default widths, the init-state enum type, and a byte-merge helper function (new data, old data, mask).
REQ-032 The init state machine and its counter SHALL be one sub-module, sram_init_fsm, with outputs init_busy, clr_we and clr_addr.
REQ-033 The array SHALL be a single inferred memory with one write path; the clear write is muxed ahead of the port 0 write.

Verification
REQ-034 Reset with defaults; hold rst 3 cycles, then release -> init_busy stays high 256 cycles, then falls; reads of addresses 0x00 and 0xFF both return 0x00000000.
REQ-035 Write 0xDEADBEEF to 0x10 with wmask0=0xF; next cycle read port 0 at 0x10 -> dout0=0xDEADBEEF one cycle later.
REQ-036 Write 0x11223344 to 0x10 with wmask0=0x5 over 0xDEADBEEF -> a port 1 read returns 0xDE22BE44.
REQ-037 Same cycle: port 0 writes 0xCAFEF00D to 0x20 with wmask0=0x3 over 0xAAAAAAAA, and port 1 reads 0x20 -> dout1=0xAAAAF00D next cycle.
REQ-038 Pulse rst when clr_addr=0x80 -> the clear restarts; init_busy stays high 256 cycles after the new rst release; port writes issued meanwhile have no effect.
REQ-039 With csb0=csb1=1 for 5 cycles after a read of 0x12345678 -> dout0 and dout1 hold their previous values.
